// File: rtl/note_lane_if.sv
// Note-lane renderer bus: beatmap row handshake, scroll request and pixel stream.
// Optional HIT_WINDOW_EN adds the hit_window lane flags.
interface note_lane_if #(
   parameter int LANES = 4
);
   logic             step_en;
   logic [LANES-1:0] note_in;
   logic             note_valid;
   logic             note_take;
   logic             underrun;
   logic [8:0]       x;
   logic [7:0]       y;
   logic [2:0]       colour;
   logic             frame_start;
`ifdef HIT_WINDOW_EN
   logic [LANES-1:0] hit_window;

   modport master (
      output step_en, note_in, note_valid,
      input  note_take, underrun, x, y, colour, frame_start, hit_window
   );
   modport slave (
      input  step_en, note_in, note_valid,
      output note_take, underrun, x, y, colour, frame_start, hit_window
   );
`else
   modport master (
      output step_en, note_in, note_valid,
      input  note_take, underrun, x, y, colour, frame_start
   );
   modport slave (
      input  step_en, note_in, note_valid,
      output note_take, underrun, x, y, colour, frame_start
   );
`endif
endinterface

// File: rtl/note_lane_renderer.sv
// Scrolling note-lane renderer: LANES lanes of a ROWS-deep note shift register drawn as a pixel stream.
// Define HIT_WINDOW_EN to add the registered hit_window output.
//
// state     | meaning
// ST_ORIGIN | just out of reset; next edge presents (0,0) without advancing
// ST_SCAN   | raster running; steps applied on the frame wrap
module note_lane_renderer #(
   parameter int                 LANES        = 4,
   parameter int                 ROWS         = 11,
   parameter int                 ROW_H        = 20,
   parameter int                 NOTE_H       = 10,
   parameter int                 STEP_PX      = 4,
   parameter int                 SCREEN_W     = 320,
   parameter int                 SCREEN_H     = 240,
   parameter int                 LANE_X0      = 125,
   parameter int                 LANE_W       = 16,
   parameter int                 LANE_GAP     = 2,
   parameter int                 HIT_Y        = 220,
   parameter logic [3*LANES-1:0] LANE_COLOURS = 12'b100_011_110_101
) (
   input logic         clk,
   input logic         resetn,
   note_lane_if.slave  bus
);
   localparam int OFF_W   = $clog2(ROW_H + STEP_PX + 1);
   localparam int PITCH   = LANE_W + LANE_GAP;
   localparam int LAST_HI = LANE_X0 + LANES*PITCH - LANE_GAP - 1;

   typedef logic [15:0] coord_t;
   typedef enum logic {ST_ORIGIN, ST_SCAN} state_t;

   state_t           state;
   logic [OFF_W-1:0] offset, offset_nxt, off_sum;
   logic [LANES-1:0] rows     [ROWS];
   logic [LANES-1:0] rows_nxt [ROWS];
   logic             step_pending, pending_nxt;
   logic [8:0]       x_nxt;
   logic [7:0]       y_nxt;
   logic             wrap, apply, shift;
   logic [2:0]       colour_nxt;

   always_comb begin
      x_nxt = bus.x;
      y_nxt = bus.y;
      if (state == ST_ORIGIN) begin
         x_nxt = '0;
         y_nxt = '0;
      end else if (bus.x == 9'(SCREEN_W-1)) begin
         x_nxt = '0;
         y_nxt = (bus.y == 8'(SCREEN_H-1)) ? '0 : bus.y + 8'd1;
      end else begin
         x_nxt = bus.x + 9'd1;
      end
   end

   // Scroll only moves on the frame wrap so a frame is drawn from one consistent state.
   always_comb begin
      wrap        = (state == ST_SCAN) && (bus.x == 9'(SCREEN_W-1)) && (bus.y == 8'(SCREEN_H-1));
      apply       = wrap && (step_pending || bus.step_en);
      off_sum     = offset + OFF_W'(STEP_PX);
      shift       = apply && (off_sum >= OFF_W'(ROW_H));
      offset_nxt  = offset;
      if (apply)
         offset_nxt = shift ? off_sum - OFF_W'(ROW_H) : off_sum;
      pending_nxt = apply ? 1'b0 : (step_pending || bus.step_en);
   end

   always_comb begin
      for (int r = 0; r < ROWS; r++)
         rows_nxt[r] = rows[r];
      if (shift) begin
         for (int r = ROWS-1; r > 0; r--)
            rows_nxt[r] = rows[r-1];
         rows_nxt[0] = bus.note_valid ? bus.note_in : '0;
      end
   end

   // Colour is evaluated for the next pixel against the next scroll state, so the
   // registered colour lines up with the registered x,y.
   always_comb begin : colour_logic
      coord_t     px, py, lo, top;
      logic       in_lane, in_sep, note_hit;
      logic [2:0] note_col;
      px       = coord_t'(x_nxt);
      py       = coord_t'(y_nxt);
      lo       = '0;
      top      = '0;
      in_lane  = 1'b0;
      in_sep   = 1'b0;
      note_hit = 1'b0;
      note_col = '0;
      for (int i = 0; i < LANES; i++) begin
         lo = coord_t'(LANE_X0 + i*PITCH);
         if (px >= lo && px <= lo + coord_t'(LANE_W-1)) begin
            in_lane = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
               top = coord_t'(r*ROW_H) + coord_t'(offset_nxt);
               if (rows_nxt[r][i] && py >= top && py <= top + coord_t'(NOTE_H-1) &&
                   py < coord_t'(HIT_Y)) begin
                  note_hit = 1'b1;
                  note_col = LANE_COLOURS[3*i +: 3];
               end
            end
         end
         if (px + coord_t'(LANE_GAP) >= lo && px < lo)
            in_sep = 1'b1;
      end
      if (px > coord_t'(LAST_HI) && px <= coord_t'(LAST_HI + LANE_GAP))
         in_sep = 1'b1;

      if (in_lane && (py == coord_t'(HIT_Y) || py == coord_t'(HIT_Y+1)))
         colour_nxt = 3'b000;
      else if (note_hit)
         colour_nxt = note_col;
      else if (in_sep)
         colour_nxt = 3'b000;
      else
         colour_nxt = 3'b111;
   end

`ifdef HIT_WINDOW_EN
   logic [LANES-1:0] hit_nxt;

   always_comb begin : hit_logic
      coord_t htop;
      htop    = '0;
      hit_nxt = '0;
      for (int i = 0; i < LANES; i++)
         for (int r = 0; r < ROWS; r++) begin
            htop = coord_t'(r*ROW_H) + coord_t'(offset_nxt);
            if (rows_nxt[r][i] && htop <= coord_t'(HIT_Y-1) &&
                htop + coord_t'(NOTE_H-1+ROW_H) >= coord_t'(HIT_Y))
               hit_nxt[i] = 1'b1;
         end
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state           <= ST_ORIGIN;
         bus.x           <= '0;
         bus.y           <= '0;
         bus.colour      <= '0;
         bus.frame_start <= 1'b0;
         bus.note_take   <= 1'b0;
         bus.underrun    <= 1'b0;
         offset          <= '0;
         step_pending    <= 1'b0;
         for (int r = 0; r < ROWS; r++)
            rows[r] <= '0;
`ifdef HIT_WINDOW_EN
         bus.hit_window  <= '0;
`endif
      end else begin
         state           <= ST_SCAN;
         bus.x           <= x_nxt;
         bus.y           <= y_nxt;
         bus.colour      <= colour_nxt;
         bus.frame_start <= (x_nxt == 9'd0) && (y_nxt == 8'd0);
         bus.note_take   <= shift;
         bus.underrun    <= bus.underrun | (shift & ~bus.note_valid);
         offset          <= offset_nxt;
         step_pending    <= pending_nxt;
         for (int r = 0; r < ROWS; r++)
            rows[r] <= rows_nxt[r];
`ifdef HIT_WINDOW_EN
         if (apply)
            bus.hit_window <= hit_nxt;
`endif
      end
   end
endmodule

// File: doc/note_lane_renderer.md
Name: note_lane_renderer

Overview:
- Parametrised successor to the fixed 4-lane beat renderer: LANES scrolling note lanes drawn into a SCREEN_W x SCREEN_H pixel stream, one pixel per clk.
- Holds a ROWS-deep row shift register of note bits and a sub-row scroll offset.
- Takes new note rows from the beatmap ROM side over a valid/take handshake. Scroll steps are applied only at frame boundaries, so the picture never tears.
- Replaces derived-clock scrolling with a single clock plus enable pulses.

Parameters:
- LANES, 4, number of note lanes (1..8)
- ROWS, 11, note rows held on screen
- ROW_H, 20, pixel pitch between rows
- NOTE_H, 10, note body height in pixels
- STEP_PX, 4, pixels scrolled per applied step (1..ROW_H)
- SCREEN_W, 320, active width
- SCREEN_H, 240, active height
- LANE_X0, 125, x of lane 0 left edge
- LANE_W, 16, lane width
- LANE_GAP, 2, black separator width
- HIT_Y, 220, first row of the 2-pixel hit line
- LANE_COLOURS, 12'b100_011_110_101, 3 bits per lane; lane i uses [3i+:3]

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- step_en  in  1  one-cycle scroll request pulse
- note_in  in  LANES  next row, bit i = note in lane i
- note_valid  in  1  note_in holds a valid row
- note_take  out  1  one-cycle pulse: note_in consumed this cycle
- underrun  out  1  sticky: a row shift found note_valid low
- x  out  9  pixel x
- y  out  8  pixel y
- colour  out  3  pixel colour for (x,y) in the same cycle
- frame_start  out  1  high in the cycle x=0,y=0 is presented

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. While resetn is low at a clk edge:
  - x=0, y=0, colour=0, note_take=0, underrun=0, frame_start=0.
  - offset=0, all rows cleared, step_pending=0.
  - Reset mid-frame or mid-shift abandons everything. No partial shift survives.
- Scan counters:
  - x counts 0..SCREEN_W-1 and wraps to 0.
  - On wrap, y counts 0..SCREEN_H-1 and wraps to 0.
  - The first cycle after reset release presents (0,0).
- x, y, colour and frame_start are all registered together, so colour always matches the x,y shown beside it.
- step_en sets step_pending. Any number of pulses within one frame collapse into one step.
- Step application happens in the cycle the scan wraps from (SCREEN_W-1,SCREEN_H-1) to (0,0), if step_pending is set (including a step_en arriving that same cycle). step_pending clears. Then:
  - If offset+STEP_PX < ROW_H: offset += STEP_PX.
  - Else (shift):
    - offset = offset+STEP_PX-ROW_H.
    - row[k] <= row[k-1] for k=ROWS-1..1; old row[ROWS-1] is discarded.
    - row[0] <= note_valid ? note_in : 0.
    - note_take = 1 for this one cycle, regardless of note_valid.
    - If note_valid = 0, underrun <= 1. underrun is cleared only by reset.
- Geometry:
  - lane i spans x in [LANE_X0+i*(LANE_W+LANE_GAP), +LANE_W-1].
  - The LANE_GAP columns immediately left of each lane and right of the last lane are separators.
  - Row r top edge is r*ROW_H+offset. Its note body covers y in [top, top+NOTE_H-1], clipped to y<HIT_Y.
  - Compute these with widths wide enough to avoid overflow at ROWS*ROW_H+ROW_H.
- Colour priority, per pixel:
  1. Lane x and y in {HIT_Y, HIT_Y+1} -> 000.
  2. Lane i x, and any row r with row[r][i]=1 covers y -> lane i colour.
  3. Separator x -> 000.
  4. Otherwise 111.

Optional Feature:
- HIT_WINDOW_EN defined: adds output hit_window [LANES-1:0], registered and updated at each step application. Bit i = 1 iff some row r with row[r][i]=1 has a body overlapping y range [HIT_Y-ROW_H, HIT_Y-1] after that step.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-frame: hold resetn=0 for 3 clk at (200,100) -> x=0,y=0,colour=000,underrun=0. Next cycle presents (0,0) with colour 111.
- Scan wrap: run 76800 clk after reset -> x,y back to (0,0). frame_start pulses exactly once per 76800 cycles.
- Static chrome: empty rows -> (123,5)=000, (141,5)=000, (130,220)=000, (130,221)=000, (130,50)=111, (10,220)=111.
- Note entry: note_valid=1, note_in=4'b0001, one step_en per frame for 5 frames -> note_take pulses once, at the 5th application. Next frame: (125,0)..(140,9)=101, (125,10)=111, lane 1 (143,0)=111.
- Step collapse: 3 step_en pulses in one frame -> offset advances by exactly 4. A row at top 0 moves to top 4: pixel (125,3)=111, (125,4)=101.
- Underrun: note_valid=0 at a shift -> row 0 empty, note_take pulses, underrun=1 and stays 1 through later valid shifts until resetn=0.
